// File: rtl/traffic_lights_monitor_if.sv
// Lamp lines from a UK traffic-light sequencer to anything observing them.
interface traffic_lights_monitor_if;
   logic red;
   logic amber;
   logic green;

   // Sequencer side drives the lamps
   modport master (output red, output amber, output green);
   // Monitor side only observes the lamps
   modport slave  (input  red, input  amber, input  green);
endinterface

// File: rtl/traffic_lights_monitor.sv
// Protocol monitor for the R -> RA -> G -> A lamp sequence: decodes the phase,
// flags bad patterns, bad transitions and over-long phases, and counts wraps.
module traffic_lights_monitor #(
   parameter int unsigned MAX_HOLD = 1,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   traffic_lights_monitor_if.slave       lamps,
   output logic [1:0]                    phase,
   output logic                          phase_valid,
   output logic                          err,
   output logic [1:0]                    err_code,
   output logic [CNT_W-1:0]              seq_count
);

   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 2);

   localparam logic [1:0] PH_A       = 2'b11;
   localparam logic [1:0] E_PATTERN  = 2'b01;
   localparam logic [1:0] E_TRANS    = 2'b10;
   localparam logic [1:0] E_HOLD     = 2'b11;

   typedef enum logic {S_SYNC, S_TRACK} state_t;

   state_t              state, state_d;
   logic [HOLD_W-1:0]   hold, hold_d, hold_inc;
   logic [1:0]          phase_d;
   logic                phase_valid_d;
   logic                err_d;
   logic [1:0]          err_code_d;
   logic [CNT_W-1:0]    seq_count_d;
   logic [2:0]          pat;
   logic                legal;
   logic [1:0]          dec;
   logic                err_hit;
   logic [1:0]          err_new;

   // Lamp pattern decode into phase; anything outside the four legal patterns is illegal
   always_comb begin
      pat   = {lamps.red, lamps.amber, lamps.green};
      legal = 1'b1;
      dec   = 2'b00;
      case (pat)
         3'b100:  dec = 2'b00;
         3'b110:  dec = 2'b01;
         3'b001:  dec = 2'b10;
         3'b010:  dec = 2'b11;
         default: legal = 1'b0;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state;
      hold_d        = hold;
      phase_d       = phase;
      phase_valid_d = phase_valid;
      err_d         = err;
      err_code_d    = err_code;
      seq_count_d   = seq_count;
      err_hit       = 1'b0;
      err_new       = 2'b00;
      hold_inc      = (hold == {HOLD_W{1'b1}}) ? hold : hold + HOLD_W'(1);

      case (state)
         S_SYNC: begin
            if (legal) begin
               state_d       = S_TRACK;
               phase_d       = dec;
               phase_valid_d = 1'b1;
               hold_d        = HOLD_W'(1);
            end else begin
               err_hit = 1'b1;
               err_new = E_PATTERN;
            end
         end
         S_TRACK: begin
            if (!legal) begin
               err_hit = 1'b1;
               err_new = E_PATTERN;
            end else if (dec == phase) begin
               hold_d = hold_inc;
               if (hold_inc > HOLD_W'(MAX_HOLD)) begin
                  err_hit = 1'b1;
                  err_new = E_HOLD;
               end
            end else if (dec == 2'(phase + 2'd1)) begin
               phase_d = dec;
               hold_d  = HOLD_W'(1);
               if (phase == PH_A && seq_count != {CNT_W{1'b1}})
                  seq_count_d = seq_count + CNT_W'(1);
            end else begin
               err_hit = 1'b1;
               err_new = E_TRANS;
            end
            // Any error while tracking drops back to SYNC
            if (err_hit) begin
               state_d       = S_SYNC;
               phase_valid_d = 1'b0;
               hold_d        = '0;
            end
         end
         default: state_d = S_SYNC;
      endcase

      // Sticky error; only the first code since reset is kept
      if (err_hit) begin
         err_d = 1'b1;
         if (!err) err_code_d = err_new;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_SYNC;
         hold        <= '0;
         phase       <= 2'b00;
         phase_valid <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
         seq_count   <= '0;
      end else begin
         state       <= state_d;
         hold        <= hold_d;
         phase       <= phase_d;
         phase_valid <= phase_valid_d;
         err         <= err_d;
         err_code    <= err_code_d;
         seq_count   <= seq_count_d;
      end
   end

endmodule

// File: tb/tb_traffic_lights_monitor.sv
// Bench for traffic_lights_monitor: three instances (MAX_HOLD=1/CNT_W=8,
// MAX_HOLD=3/CNT_W=8, MAX_HOLD=1/CNT_W=2) watch the same lamp lines.
module tb_traffic_lights_monitor;

   logic clk;
   logic rst;
   traffic_lights_monitor_if lamps();

   logic [1:0] phase_o    [3];
   logic       valid_o    [3];
   logic       err_o      [3];
   logic [1:0] code_o     [3];
   logic [7:0] seq_a, seq_b;
   logic [1:0] seq_c;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   traffic_lights_monitor #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
      .clk(clk), .rst(rst), .lamps(lamps), .phase(phase_o[0]), .phase_valid(valid_o[0]),
      .err(err_o[0]), .err_code(code_o[0]), .seq_count(seq_a));
   traffic_lights_monitor #(.MAX_HOLD(3), .CNT_W(8)) u_h3 (
      .clk(clk), .rst(rst), .lamps(lamps), .phase(phase_o[1]), .phase_valid(valid_o[1]),
      .err(err_o[1]), .err_code(code_o[1]), .seq_count(seq_b));
   traffic_lights_monitor #(.MAX_HOLD(1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .lamps(lamps), .phase(phase_o[2]), .phase_valid(valid_o[2]),
      .err(err_o[2]), .err_code(code_o[2]), .seq_count(seq_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: position in the R,RA,G,A cycle, run length, first error
   typedef struct {
      bit synced;
      int ph;
      int run;
      bit err;
      int code;
      int cnt;
   } mdl_t;

   mdl_t m [3];
   int   max_hold [3] = '{1, 3, 1};
   int   cnt_max  [3] = '{255, 255, 3};

   function automatic mdl_t flag(mdl_t s, int c);
      mdl_t n = s;
      if (!n.err) n.code = c;
      n.err    = 1;
      n.synced = 0;
      return n;
   endfunction

   function automatic mdl_t step(mdl_t s, bit r, bit a, bit g, bit rs, int mh, int cm);
      mdl_t n = s;
      int   d;
      int   pos [8] = '{-1, 2, 3, -1, 0, -1, 1, -1};   // index {r,a,g}
      if (rs) begin
         n = '{0, 0, 0, 0, 0, 0};
         return n;
      end
      d = pos[{r, a, g}];
      if (!n.synced) begin
         if (d < 0) n = flag(n, 1);
         else begin n.synced = 1; n.ph = d; n.run = 1; end
      end else if (d < 0) n = flag(n, 1);
      else if (d == n.ph) begin
         n.run++;
         if (n.run > mh) n = flag(n, 3);
      end else if (d == (n.ph + 1) % 4) begin
         if (n.ph == 3 && n.cnt < cm) n.cnt++;
         n.ph  = d;
         n.run = 1;
      end else n = flag(n, 2);
      return n;
   endfunction

   // Advance the model on every sampling edge
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         m[i] = step(m[i], lamps.red, lamps.amber, lamps.green, rst, max_hold[i], cnt_max[i]);
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every instance against the model away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         int seqs [3];
         seqs[0] = int'(seq_a);
         seqs[1] = int'(seq_b);
         seqs[2] = int'(seq_c);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d.phase_valid", i), int'(valid_o[i]), int'(m[i].synced));
            chk($sformatf("dut%0d.err", i),         int'(err_o[i]),   int'(m[i].err));
            chk($sformatf("dut%0d.err_code", i),    int'(code_o[i]),  m[i].code);
            chk($sformatf("dut%0d.seq_count", i),   seqs[i],          m[i].cnt);
            if (m[i].synced)
               chk($sformatf("dut%0d.phase", i), int'(phase_o[i]), m[i].ph);
         end
      end
   end

   localparam logic [2:0] L_R = 3'b100, L_RA = 3'b110, L_G = 3'b001, L_A = 3'b010;

   // Present one sample for one edge; returns at the following negedge
   task automatic cyc(logic [2:0] l, bit rs = 0);
      {lamps.red, lamps.amber, lamps.green} = l;
      rst = rs;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic full_cycles(int n);
      for (int k = 0; k < n; k++) begin
         cyc(L_R); cyc(L_RA); cyc(L_G); cyc(L_A);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0};
      rst = 1'b1;
      {lamps.red, lamps.amber, lamps.green} = L_R;
      @(negedge clk);

      // Reset state
      cyc(L_R, 1);
      chk_en = 1;
      chk("reset.phase", int'(phase_o[0]), 0);
      chk("reset.valid", int'(valid_o[0]), 0);
      chk("reset.err", int'(err_o[0]), 0);
      chk("reset.seq", int'(seq_a), 0);

      // Three clean cycles: phase trails the lamps by one edge
      for (int k = 0; k < 3; k++) begin
         cyc(L_R);  chk("seq.phase_r",  int'(phase_o[0]), 0);
         cyc(L_RA); chk("seq.phase_ra", int'(phase_o[0]), 1);
         cyc(L_G);  chk("seq.phase_g",  int'(phase_o[0]), 2);
         cyc(L_A);  chk("seq.phase_a",  int'(phase_o[0]), 3);
      end
      chk("seq.count", int'(seq_a), 2);
      chk("seq.err", int'(err_o[0]), 0);
      chk("seq.valid", int'(valid_o[0]), 1);

      // Reverse transition R,RA,R then resync on G
      cyc(L_R, 1);
      cyc(L_R); cyc(L_RA); cyc(L_R);
      chk("rev.err", int'(err_o[0]), 1);
      chk("rev.code", int'(code_o[0]), 2);
      chk("rev.valid", int'(valid_o[0]), 0);
      cyc(L_G);
      chk("resync.valid", int'(valid_o[0]), 1);
      chk("resync.phase", int'(phase_o[0]), 2);
      chk("resync.seq", int'(seq_a), 0);
      cyc(L_A);
      chk("resync.seq_a", int'(seq_a), 0);
      cyc(L_R);

      // Illegal pattern after G, then a skip keeps the first code
      cyc(L_R, 1);
      cyc(L_R); cyc(L_RA); cyc(L_G); cyc(3'b101);
      chk("pat.code", int'(code_o[0]), 1);
      chk("pat.valid", int'(valid_o[0]), 0);
      cyc(L_R); cyc(L_G);
      chk("skip.err", int'(err_o[0]), 1);
      chk("skip.code", int'(code_o[0]), 1);

      // Holds: G for 3 then A is fine with MAX_HOLD=3, G for 4 is not
      cyc(L_R, 1);
      cyc(L_R); cyc(L_RA); cyc(L_G); cyc(L_G); cyc(L_G); cyc(L_A);
      chk("hold3.err", int'(err_o[1]), 0);
      chk("hold3.phase", int'(phase_o[1]), 3);
      chk("hold1.code", int'(code_o[0]), 3);
      cyc(L_R); cyc(L_RA); cyc(L_G); cyc(L_G); cyc(L_G);
      chk("hold4.err_pre", int'(err_o[1]), 0);
      cyc(L_G);
      chk("hold4.err", int'(err_o[1]), 1);
      chk("hold4.code", int'(code_o[1]), 3);
      chk("hold4.valid", int'(valid_o[1]), 0);

      // Illegal patterns while still in SYNC
      cyc(L_R, 1);
      cyc(3'b000);
      chk("sync.code", int'(code_o[0]), 1);
      cyc(3'b111);
      chk("sync.code2", int'(code_o[0]), 1);
      cyc(L_R); cyc(L_RA);
      chk("sync.valid", int'(valid_o[0]), 1);
      chk("sync.phase", int'(phase_o[0]), 1);

      // Saturation of a 2-bit wrap count, then reset mid RA
      cyc(L_R, 1);
      full_cycles(5);
      cyc(L_R);
      chk("sat.seq2", int'(seq_c), 3);
      chk("sat.seq8", int'(seq_a), 5);
      cyc(L_RA);
      cyc(L_RA, 1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("midrst%0d.valid", i), int'(valid_o[i]), 0);
         chk($sformatf("midrst%0d.err", i), int'(err_o[i]), 0);
         chk($sformatf("midrst%0d.phase", i), int'(phase_o[i]), 0);
      end
      chk("midrst.seq2", int'(seq_c), 0);
      cyc(L_RA);
      cyc(L_G);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
